// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot-time program loader.
package mips_loader_pkg;

    localparam int unsigned IMEM_DEPTH    = 8192;
    localparam int unsigned LOADER_ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [31:0] END_MARKER    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/mips_program_loader_byte_packer.sv
// byte_packer: shifts accepted bytes MSB-first into a 32-bit word.
// Ports:
//   clk1, rst_n  - clock, async active-low reset
//   clear        - restart byte counting (new load)
//   shift_en     - a byte is accepted this cycle
//   in_data      - byte to shift in
//   word         - assembled word register
//   word_full_c  - this cycle's byte completes a word (combinational)
module byte_packer (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_full_c
);

    logic [1:0] byte_cnt;

    // Shift register and byte counter; a partial word is simply overwritten
    // by the next load because the counter restarts from zero.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // The 4th byte wraps the counter 3 -> 0.
    always_comb begin
        word_full_c = shift_en && (byte_cnt == 2'd3);
    end

endmodule

// File: rtl/mips_program_loader.sv
// mips_program_loader: receives the program as a byte stream, packs it into
// 32-bit instructions and writes them to instruction memory from word 0,
// holding the CPU until the end-marker word has been written.
// Ports:
//   clk1, rst_n  - clock, async active-low reset
//   start        - begin a load (honoured in IDLE/DONE/ERROR)
//   in_valid/in_data/in_ready - byte stream handshake
//   imem_we/imem_addr/imem_wdata - instruction-memory write port
//   cpu_hold     - pipeline hold
//   done, err    - load finished with marker / memory filled without marker
//   word_count   - words written including the marker
//   halt_pc      - byte address of the marker word
module mips_program_loader #(
    parameter int unsigned ADDR_W     = mips_loader_pkg::LOADER_ADDR_W,
    parameter logic [31:0] END_MARKER = mips_loader_pkg::END_MARKER
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       halt_pc
);

    import mips_loader_pkg::*;

    loader_state_e state;
    logic          start_ok_c;
    logic          shift_en_c;
    logic          word_full_c;

    // start is only honoured while no load is in progress.
    always_comb begin
        start_ok_c = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                               (state == ST_ERROR));
        shift_en_c = in_valid && in_ready;
    end

    // The packer's word register is the memory write data directly.
    byte_packer u_byte_packer (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .clear       (start_ok_c),
        .shift_en    (shift_en_c),
        .in_data     (in_data),
        .word        (imem_wdata),
        .word_full_c (word_full_c)
    );

    // Load FSM; imem_addr doubles as the running word address.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            halt_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_RECV;
                        in_ready   <= 1'b1;
                        imem_addr  <= '0;
                        word_count <= '0;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (word_full_c) begin
                        state    <= ST_WRITE;
                        in_ready <= 1'b0;
                        imem_we  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (imem_wdata == END_MARKER) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        halt_pc  <= 32'({imem_addr, 2'b00});
                    end else if (imem_addr == {ADDR_W{1'b1}}) begin
                        state <= ST_ERROR;
                        err   <= 1'b1;
                    end else begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        state     <= ST_RECV;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected memory writes are
// queued as words are sent; a negedge monitor checks every write.
module tb_mips_program_loader;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [12:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [13:0] word_count;
    logic [31:0] halt_pc;

    always #5 clk1 = ~clk1;

    mips_program_loader dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .halt_pc    (halt_pc)
    );

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard, and the
    // strobe must never stay high for two cycles.
    always @(negedge clk1) begin
        if (rst_n && imem_we) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("write_data", imem_wdata, mon_e.data);
            end
        end
        prev_we = rst_n && imem_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n;
        bit  r;
        if (gaps) begin
            n = $urandom_range(0, 3);
            if (n != 0) in_valid = 1'b0;
            repeat (n) begin
                @(posedge clk1);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk1);
            r = in_ready;
            @(posedge clk1);
            #1;
            if (r) return;
        end
        checks++;
        errors++;
        $display("FAIL byte_timeout: got no accept expected accept of %h", b);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [12:0] a, input bit gaps);
        sb_q.push_back('{addr: a, data: w});
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk1);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_halt_pc"},    halt_pc,         32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    endtask

    // Called in the WRITE cycle of the marker word.
    task automatic check_finished(input string tag, input int wc, input int pc);
        check({tag, "_marker_we"},        32'(imem_we),  32'd1);
        check({tag, "_done_before"},      32'(done),     32'd0);
        check({tag, "_hold_before"},      32'(cpu_hold), 32'd1);
        @(posedge clk1);
        #1;
        check({tag, "_done"},       32'(done),       32'd1);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'(wc));
        check({tag, "_halt_pc"},    halt_pc,         32'(pc));
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    endtask

    task automatic send_program(input bit gaps);
        send_word(32'h2008_0005, 13'd0, gaps);
        send_word(32'h2009_0007, 13'd1, gaps);
        send_word(32'hFFFF_FFFF, 13'd2, gaps);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk1);
        #1;
        check_reset_values("reset");
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Back-to-back stream.
        pulse_start();
        check("start_in_ready", 32'(in_ready), 32'd1);
        send_program(1'b0);
        check_finished("burst", 3, 8);

        // Reload from DONE with a gappy source.
        pulse_start();
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_done", 32'(done),     32'd0);
        send_program(1'b1);
        check_finished("gappy", 3, 8);

        // Asynchronous reset after six bytes.
        pulse_start();
        send_word(32'h2008_0005, 13'd0, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h09, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk1);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk1);
        #1;
        start = 1'b0;
        check("start_at_rst_release", 32'(in_ready), 32'd1);
        send_program(1'b0);
        check_finished("after_rst", 3, 8);

        // One-word program.
        pulse_start();
        check("oneword_hold", 32'(cpu_hold), 32'd1);
        send_word(32'hFFFF_FFFF, 13'd0, 1'b0);
        in_valid = 1'b0;
        check_finished("oneword", 1, 0);

        // Fill memory without a marker.
        pulse_start();
        for (int i = 0; i < 8192; i++) send_word({16'(i), 16'hA5A5}, 13'(i), 1'b0);
        in_valid = 1'b0;
        @(posedge clk1);
        #1;
        check("full_err",        32'(err),        32'd1);
        check("full_cpu_hold",   32'(cpu_hold),   32'd1);
        check("full_done",       32'(done),       32'd0);
        check("full_word_count", 32'(word_count), 32'd8192);
        check("full_last_addr",  32'(imem_addr),  32'd8191);
        check("full_in_ready",   32'(in_ready),   32'd0);
        pulse_start();
        check("restart_err",        32'(err),        32'd0);
        check("restart_in_ready",   32'(in_ready),   32'd1);
        check("restart_word_count", 32'(word_count), 32'd0);

        repeat (2) @(posedge clk1);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_program_loader.md
# mips_program_loader

Boot-time program loader for `pipelined_mips`. It accepts the machine program as a byte stream with a valid/ready handshake, packs bytes MSB-first into 32-bit instructions, and writes them sequentially into instruction memory from word 0. It holds the pipeline with `cpu_hold` until the `32'hFFFF_FFFF` end marker has been written, then releases the core and reports the marker's byte address. This replaces file-based memory preload in synthesizable builds.

## Interface
- `ADDR_W`, 13, instruction-memory word-address width (8192 words)
- `END_MARKER`, 32'hFFFF_FFFF, end-of-program instruction word
- `clk1` in 1: the single clock; all state changes on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- `in_valid` in 1: a byte is present on `in_data`
- `in_data` in 8: program byte, most significant byte of each word first
- `in_ready` out 1: loader accepts a byte this cycle
- `imem_we` out 1: instruction-memory write strobe, one cycle per word
- `imem_addr` out ADDR_W: word address of the current write
- `imem_wdata` out 32: assembled instruction word
- `cpu_hold` out 1: keeps the pipeline halted while high
- `done` out 1: load completed with marker
- `err` out 1: memory filled with no marker
- `word_count` out ADDR_W+1: words written, marker included
- `halt_pc` out 32: byte address of the marker word (`addr*4`)

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE (reset state): `in_ready`=0 and `cpu_hold`=1. `start` moves to RECV and clears the byte counter, the address and `word_count`.
- RECV: `in_ready`=1. Each handshake (`in_valid && in_ready`) shifts `in_data` into the low byte of the word register (`word = {word[23:0], in_data}`) and increments the 2-bit byte counter. The handshake that makes the count wrap 3→0 moves to WRITE.
- WRITE: a single cycle. `imem_we`=1, `in_ready`=0, `imem_addr`=the current address, `imem_wdata`=the word, and `word_count` increments.
  - If the word equals `END_MARKER`, the marker is still written, `halt_pc` takes `{addr, 2'b00}` zero-extended, and the state moves to DONE.
  - Otherwise, if the address equals 2^ADDR_W−1, the state moves to ERROR.
  - Otherwise the address increments and the state returns to RECV.
- DONE: `done`=1 and `cpu_hold`=0. The state holds until `start`, which reloads with `done` cleared and `cpu_hold`=1 in the next cycle.
- ERROR: `err`=1 and `cpu_hold`=1. `start` restarts the load and clears `err`.
- `start` is ignored in RECV and WRITE.
- `in_valid` is ignored outside RECV. The source must hold `in_data` stable until the byte is accepted.
- A reset mid-load returns all state to IDLE and discards any partial word. Words already written stay in memory.

## Timing
- Reset values:
  - 0: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `done`, `err`, `word_count`, `halt_pc`
  - 1: `cpu_hold`
- `in_ready` is decoded from the state register, with no combinational path from `in_valid`.
- `imem_we` is high exactly one cycle, in the cycle after the 4th byte is accepted.
- Peak throughput is one word per 5 cycles: 4 accept cycles plus 1 WRITE cycle.
- On a marker word, `done` rises and `cpu_hold` falls in the cycle after WRITE. `halt_pc` is valid in that same cycle.
- `start` is sampled in the same cycle as `rst_n` deasserting.

## Structure
- Package `mips_loader_pkg`:
  - state enum
  - `END_MARKER`
  - `IMEM_DEPTH = 8192`
- Sub-module `byte_packer`: the shift register, the 2-bit byte counter and a `word_full` flag. The parent owns the FSM, the address and the status outputs.

## Test plan
- Stream bytes 20 08 00 05, 20 09 00 07, FF FF FF FF with `in_valid` always high. Required:
  - writes to address 0 (`32'h2008_0005`), address 1 (`32'h2009_0007`) and address 2 (marker)
  - `word_count`=3, `halt_pc`=8
  - `done`=1 and `cpu_hold`=0 in the cycle after the 3rd WRITE
- Same stream with `in_valid` toggling randomly. Required: identical memory image and results; no byte lost or duplicated.
- Pulse `rst_n` low after 6 bytes. Required:
  - all outputs at reset values immediately (asynchronous)
  - after `start`, a fresh stream lands at address 0
- Send 8192 non-marker words. Required:
  - last write at address 8191
  - `err`=1, `cpu_hold`=1, `done`=0, `word_count`=8192
- After DONE, pulse `start` and load a one-word program FF FF FF FF. Required: `cpu_hold` reasserts; `halt_pc`=0, `word_count`=1, `done`=1.
